// File: rtl/mill_trap_pkg.sv
// Shared types and constants for the trap/mret sequencing controller.
package mill_trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_e;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } trap_kind_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_1888;

endpackage

// File: rtl/trap_controller_if.sv
// Software CSR write bus, already qualified by the sequencing FSM.
interface trap_controller_if;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;

  modport master (output csr_we, output csr_addr, output csr_wdata);
  modport slave  (input  csr_we, input  csr_addr, input  csr_wdata);
endinterface

// File: rtl/trap_csr_file.sv
// Architectural machine CSRs: trap/mret commit updates and masked software writes.
module trap_csr_file
  import mill_trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst_n,
  trap_controller_if.slave  sw,
  input  logic              commit_trap,
  input  logic              commit_mret,
  input  logic [31:0]       trap_pc,
  input  logic [31:0]       trap_cause,
  output logic [31:0]       mstatus,
  output logic [31:0]       mtvec,
  output logic [31:0]       mepc,
  output logic [31:0]       mcause
);

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (commit_trap) begin
      mepc_d                                  = trap_pc;
      mcause_d                                = trap_cause;
      mstatus_d[MSTATUS_MPIE]                 = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]                  = 1'b0;
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end else if (commit_mret) begin
      mstatus_d[MSTATUS_MIE]                  = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE]                 = 1'b1;
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end else if (sw.csr_we) begin
      // Only MPP/MPIE/MIE are software-visible in mstatus; vectors are word aligned.
      case (sw.csr_addr)
        CSR_MSTATUS: mstatus_d = (mstatus_q & ~MSTATUS_WMASK) | (sw.csr_wdata & MSTATUS_WMASK);
        CSR_MTVEC:   mtvec_d   = {sw.csr_wdata[31:2], 2'b00};
        CSR_MEPC:    mepc_d    = {sw.csr_wdata[31:2], 2'b00};
        CSR_MCAUSE:  mcause_d  = sw.csr_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q <= MSTATUS_RESET;
      mtvec_q   <= MTVEC_RESET;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  assign mstatus = mstatus_q;
  assign mtvec   = mtvec_q;
  assign mepc    = mepc_q;
  assign mcause  = mcause_q;

endmodule

// File: rtl/trap_controller.sv
// Trap/mret sequencer: capture, drain outstanding memory ops, commit CSRs, redirect.
//   state    | meaning
//   IDLE     | normal execution, software CSR writes allowed
//   DRAIN    | pipeline stalled, waiting for mem_busy to fall (bounded)
//   COMMIT   | one cycle: CSR update for the recorded kind
//   REDIRECT | one cycle: redirect_valid + flush to mtvec/mepc
module trap_controller
  import mill_trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter int          DRAIN_MAX   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exp_occur,
  input  logic        mret_occur,
  input  logic [31:0] mepc_change,
  input  logic [31:0] mcause_change,
  input  logic        mem_busy,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] mstatus,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout
);

  localparam int             CW       = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DRAIN_MAX - 1);

  trap_state_e   state_q, state_d;
  trap_kind_e    kind_q, kind_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   cause_q, cause_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          commit_trap, commit_mret, sw_ok;

  trap_controller_if csr_bus ();

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    cnt_d       = '0;
    timeout_d   = timeout_q;
    commit_trap = 1'b0;
    commit_mret = 1'b0;
    sw_ok       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exp_occur) begin
          pc_d    = mepc_change;
          cause_d = mcause_change;
          kind_d  = KIND_TRAP;
          state_d = ST_DRAIN;
        end else if (mret_occur) begin
          kind_d  = KIND_MRET;
          state_d = ST_DRAIN;
        end else begin
          sw_ok = 1'b1;
        end
      end
      ST_DRAIN: begin
        // cnt_q counts completed DRAIN cycles; the last allowed one forces COMMIT.
        if (!mem_busy) begin
          state_d = ST_COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_COMMIT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        commit_trap = (kind_q == KIND_TRAP);
        commit_mret = (kind_q == KIND_MRET);
        state_d     = ST_REDIRECT;
      end
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      kind_q    <= KIND_TRAP;
      pc_q      <= '0;
      cause_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign csr_bus.csr_we    = csr_we & sw_ok;
  assign csr_bus.csr_addr  = csr_addr;
  assign csr_bus.csr_wdata = csr_wdata;

  trap_csr_file #(.MTVEC_RESET(MTVEC_RESET)) u_csr (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (csr_bus.slave),
    .commit_trap (commit_trap),
    .commit_mret (commit_mret),
    .trap_pc     (pc_q),
    .trap_cause  (cause_q),
    .mstatus     (mstatus),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .mcause      (mcause)
  );

  assign stall          = (state_q != ST_IDLE);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign flush          = (state_q == ST_REDIRECT);
  assign redirect_pc    = !redirect_valid       ? 32'h0 :
                          (kind_q == KIND_TRAP) ? mtvec : mepc;
  assign drain_timeout  = timeout_q;

endmodule

// File: tb/tb_trap_controller.sv
// Randomized scoreboard bench for trap_controller against a behavioural CSR/latency model.
module tb_trap_controller;

  localparam int DRAIN_MAX = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exp_occur = 1'b0, mret_occur = 1'b0, mem_busy = 1'b0;
  logic [31:0] mepc_change = '0, mcause_change = '0;
  logic [31:0] mstatus, mtvec, mepc, mcause, redirect_pc;
  logic        stall, flush, redirect_valid, drain_timeout;

  trap_controller_if bus ();

  trap_controller #(.MTVEC_RESET(32'h0000_0100), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exp_occur      (exp_occur),
    .mret_occur     (mret_occur),
    .mepc_change    (mepc_change),
    .mcause_change  (mcause_change),
    .mem_busy       (mem_busy),
    .csr_we         (bus.csr_we),
    .csr_addr       (bus.csr_addr),
    .csr_wdata      (bus.csr_wdata),
    .mstatus        (mstatus),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .mcause         (mcause),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .drain_timeout  (drain_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rpc, ms, tv, ep, mc;
    logic        to;
    int          at;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_ms, m_tv, m_ep, m_mc;
  logic        m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    m_ms = 32'h0000_1800; m_tv = 32'h0000_0100; m_ep = '0; m_mc = '0; m_to = 1'b0;
  endtask

  // Monitor: every redirect strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && redirect_valid) begin
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_redirect: got redirect_pc %h with no sequence pending (cycle %0d)", redirect_pc, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("redirect_cycle", cyc, e.at);
        chk("flush", {31'b0, flush}, 32'd1);
        chk("stall_redirect", {31'b0, stall}, 32'd1);
        chk("mstatus_after", mstatus, e.ms);
        chk("mtvec_after", mtvec, e.tv);
        chk("mepc_after", mepc, e.ep);
        chk("mcause_after", mcause, e.mc);
        chk("drain_timeout", {31'b0, drain_timeout}, {31'b0, e.to});
      end
    end
  end

  task automatic check_csrs(input string tag);
    chk({tag, "_mstatus"}, mstatus, m_ms);
    chk({tag, "_mtvec"}, mtvec, m_tv);
    chk({tag, "_mepc"}, mepc, m_ep);
    chk({tag, "_mcause"}, mcause, m_mc);
  endtask

  task automatic check_reset_outputs();
    check_csrs("reset");
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_flush", {31'b0, flush}, 32'd0);
    chk("reset_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("reset_drain_timeout", {31'b0, drain_timeout}, 32'd0);
  endtask

  task automatic sw_write(input logic [11:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.csr_we = 1'b1; bus.csr_addr = addr; bus.csr_wdata = data;
    @(posedge clk); #1;
    bus.csr_we = 1'b0;
    case (addr)
      12'h300: m_ms = (m_ms & ~32'h0000_1888) | (data & 32'h0000_1888);
      12'h305: m_tv = data & 32'hFFFF_FFFC;
      12'h341: m_ep = data & 32'hFFFF_FFFC;
      12'h342: m_mc = data;
      default: ;
    endcase
    check_csrs("swwrite");
  endtask

  // One trap/mret sequence; busy = number of DRAIN cycles with mem_busy high.
  task automatic do_seq(input bit is_exp, input bit both, input int busy,
                        input logic [31:0] pc, input logic [31:0] cause, input bit noise);
    int   ndrain;
    exp_t e;
    @(posedge clk); #1;
    exp_occur = is_exp; mret_occur = !is_exp || both;
    mepc_change = pc; mcause_change = cause; mem_busy = 1'b0;
    bus.csr_we = noise; bus.csr_addr = 12'h305; bus.csr_wdata = $urandom;
    ndrain = (busy + 1 < DRAIN_MAX) ? busy + 1 : DRAIN_MAX;
    if (is_exp) begin
      e.rpc = m_tv;
      m_ep = pc; m_mc = cause;
      m_ms[7] = m_ms[3]; m_ms[3] = 1'b0; m_ms[12:11] = 2'b11;
    end else begin
      e.rpc = m_ep;
      m_ms[3] = m_ms[7]; m_ms[7] = 1'b1; m_ms[12:11] = 2'b11;
    end
    if (busy >= DRAIN_MAX) m_to = 1'b1;
    e.ms = m_ms; e.tv = m_tv; e.ep = m_ep; e.mc = m_mc; e.to = m_to;
    e.at = cyc + 2 + ndrain;
    sb.push_back(e);
    for (int k = 0; k < ndrain; k++) begin
      @(posedge clk); #1;
      mem_busy   = (k < busy);
      exp_occur  = noise & $urandom_range(0, 1);
      mret_occur = noise & $urandom_range(0, 1);
      mepc_change = $urandom; mcause_change = $urandom;
      bus.csr_we = noise; bus.csr_addr = ($urandom_range(0, 1) != 0) ? 12'h305 : 12'h341;
      bus.csr_wdata = $urandom;
    end
    @(posedge clk); #1;
    exp_occur = 1'b0; mret_occur = 1'b0; mem_busy = 1'b0; bus.csr_we = 1'b0;
    for (int w = 0; w < 40 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL redirect_timeout: got no redirect within 40 cycles, expected one at cycle %0d", e.at);
      sb.delete();
    end
  endtask

  task automatic reset_in_commit();
    @(posedge clk); #1;
    exp_occur = 1'b1; mepc_change = 32'h0000_0BEC; mcause_change = 32'd7; mem_busy = 1'b0;
    @(posedge clk); #1;
    exp_occur = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_csrs("post_reset");
  endtask

  initial begin
    logic [11:0] addrs [5];
    addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341; addrs[3] = 12'h342; addrs[4] = 12'h7C0;
    bus.csr_we = 1'b0; bus.csr_addr = '0; bus.csr_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;

    sw_write(12'h300, 32'h0000_1808);
    do_seq(1'b1, 1'b0, 0, 32'h0000_0040, 32'd2, 1'b0);
    sw_write(12'h341, 32'h0000_0044);
    do_seq(1'b0, 1'b0, 0, 32'h0, 32'h0, 1'b0);
    do_seq(1'b1, 1'b0, 5, 32'h0000_0080, 32'd5, 1'b0);
    do_seq(1'b1, 1'b1, 2, 32'h0000_00C0, 32'd11, 1'b1);
    sw_write(12'h305, 32'hFFFF_FFFF);
    sw_write(12'h300, 32'hFFFF_FFFF);
    sw_write(12'h305, 32'h0000_0200);
    sw_write(12'h7C0, 32'h1234_5678);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        sw_write(addrs[$urandom_range(0, 4)], $urandom);
      else
        do_seq($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 10),
               $urandom, $urandom, $urandom_range(0, 1) != 0);
    end

    do_seq(1'b1, 1'b0, DRAIN_MAX + 4, 32'h0000_0300, 32'd3, 1'b0);
    do_seq(1'b0, 1'b0, DRAIN_MAX - 1, 32'h0, 32'h0, 1'b0);
    do_seq(1'b1, 1'b0, 0, 32'h0000_0310, 32'd4, 1'b0);

    reset_in_commit();
    do_seq(1'b1, 1'b0, 1, 32'h0000_0400, 32'd8, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion by %0t, expected finish", $time);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0100: reset value of mtvec.
REQ-002 SHALL have parameter DRAIN_MAX, default 16: maximum number of cycles spent waiting for mem_busy to fall.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-004 Ports, in order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- exp_occur  in  1  exception flagged by the EX-stage detector.
- mret_occur  in  1  mret flagged by the EX-stage detector.
- mepc_change  in  32  faulting PC.
- mcause_change  in  32  cause code.
- mem_busy  in  1  memory operation outstanding.
- csr_we  in  1  software CSR write strobe.
- csr_addr  in  12  CSR write address.
- csr_wdata  in  32  CSR write data.
- mstatus, mtvec, mepc, mcause  out  32 each  architectural CSRs.
- stall  out  1  freeze the pipeline.
- flush  out  1  kill in-flight instructions.
- redirect_valid  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  32  redirect target.
- drain_timeout  out  1  sticky flag: drain timed out.

Function
REQ-005 FSM states SHALL be IDLE, DRAIN, COMMIT and REDIRECT.
REQ-006 In IDLE, when exp_occur=1, the controller SHALL latch mepc_change and mcause_change, record kind=TRAP, and enter DRAIN on the next edge.
REQ-007 In IDLE, when mret_occur=1 and exp_occur=0, the controller SHALL record kind=MRET and enter DRAIN. exp_occur has priority when both are set.
REQ-008 exp_occur and mret_occur SHALL be ignored in every state other than IDLE.
REQ-009 DRAIN SHALL hold while mem_busy=1 and move to COMMIT on the first cycle with mem_busy=0.
REQ-010 A drain counter SHALL count DRAIN cycles. When it reaches DRAIN_MAX, the FSM SHALL enter COMMIT regardless of mem_busy and set drain_timeout.
REQ-011 COMMIT, lasting one cycle, SHALL update CSRs as follows:
- TRAP: mepc <= latched PC; mcause <= latched cause; mstatus[7] (MPIE) <= mstatus[3] (MIE); MIE <= 0; mstatus[12:11] (MPP) <= 2'b11.
- MRET: MIE <= MPIE; MPIE <= 1; MPP <= 2'b11.
- Other mstatus bits SHALL be unchanged.
REQ-012 REQ-011 completes in one cycle, after which the FSM SHALL enter REDIRECT.
REQ-013 REDIRECT, lasting one cycle, SHALL assert redirect_valid=1 and flush=1. redirect_pc SHALL be mtvec for TRAP and mepc for MRET. The FSM then returns to IDLE.
REQ-014 stall SHALL be 1 in DRAIN, COMMIT and REDIRECT, and SHALL be a combinational function of state.
REQ-015 Minimum latency from exp_occur to redirect_valid SHALL be 3 cycles (DRAIN, COMMIT, REDIRECT).
REQ-016 csr_we SHALL take effect in IDLE only, and only when exp_occur=0 and mret_occur=0. Otherwise it SHALL be dropped.
REQ-017 Software CSR write addresses and masking:
- 12'h300 writes mstatus bits [12:11], [7] and [3] only.
- 12'h305 writes mtvec with bits [1:0] forced to 00.
- 12'h341 writes mepc with bits [1:0] forced to 00.
- 12'h342 writes mcause.
- Any other address is ignored.
REQ-018 drain_timeout SHALL remain set until reset.

Reset
REQ-019 While rst_n=0, state SHALL be IDLE and all of the following SHALL hold:
- mstatus=32'h0000_1800, mtvec=MTVEC_RESET, mepc=0, mcause=0.
- stall=0, flush=0, redirect_valid=0, redirect_pc=0, drain_timeout=0, drain counter=0.
REQ-020 Reset asserted mid-sequence SHALL abandon the sequence with no CSR update and no redirect pulse.

Structure
REQ-021 Package mill_trap_pkg SHALL hold:
- the state enum and the TRAP/MRET kind enum;
- CSR address constants (300, 305, 341, 342);
- mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
REQ-022 Sub-module trap_csr_file SHALL hold the four CSR registers and their write-masking logic. The FSM and drain counter SHALL stay in trap_controller.

Verification
REQ-023 Exception path: exp_occur=1, mepc_change=32'h0000_0040, mcause_change=2, mem_busy=0, mstatus=32'h0000_1808 -> redirect_valid at cycle +3 with redirect_pc=32'h0000_0100; mepc=32'h40, mcause=2, mstatus=32'h0000_1880.
REQ-024 mret path: mret_occur=1 with mstatus=32'h0000_1880, mepc=32'h0000_0044 -> redirect_pc=32'h44; mstatus=32'h0000_1888.
REQ-025 Drain hold: mem_busy held high for 5 cycles after capture -> COMMIT on the 6th cycle; drain_timeout=0. With DRAIN_MAX=16 and mem_busy stuck at 1 -> COMMIT after 16 DRAIN cycles; drain_timeout=1.
REQ-026 Collision: exp_occur=1 and mret_occur=1 together with csr_we to 12'h305 -> TRAP taken; mtvec unchanged. A second exp_occur during DRAIN is ignored.
REQ-027 CSR masking: write 32'hFFFF_FFFF to 12'h305 -> mtvec=32'hFFFF_FFFC. Write 32'hFFFF_FFFF to 12'h300 -> mstatus=32'h0000_1888.
REQ-028 Reset in COMMIT: rst_n pulsed low -> all CSRs return to reset values; no redirect_valid pulse.
